// File: rtl/alu_seq_if.sv
// alu_seq_if: command/result handshake bundle between operand issue and writeback
interface alu_seq_if #(parameter int WIDTH = 64);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               a_invert;
    logic               b_invert;
    logic               carry_in;
    logic [2:0]         operation;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;
    logic               carry_out;
    logic               zero;
    logic               overflow;
    modport master (
        output in_valid, a, b, a_invert, b_invert, carry_in, operation, out_ready,
        input  in_ready, out_valid, result, carry_out, zero, overflow
    );
    modport slave (
        input  in_valid, a, b, a_invert, b_invert, carry_in, operation, out_ready,
        output in_ready, out_valid, result, carry_out, zero, overflow
    );
endinterface

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked ALU with registered result/flags and a WIDTH-cycle shift-add multiply
module alu_seq_unit #(
    parameter int WIDTH = 64
) (
    input logic      clk,
    input logic      reset,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_x, b_x, sum, slt_res, alu_lo;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, acc_n, result_q, result_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               c_out, ovf, is_arith, is_mul;
    logic               carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d;
    assign a_x      = bus.a_invert ? ~bus.a : bus.a;
    assign b_x      = bus.b_invert ? ~bus.b : bus.b;
    assign {c_out, sum} = {1'b0, a_x} + {1'b0, b_x} + {{WIDTH{1'b0}}, bus.carry_in};
    assign ovf      = (a_x[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != a_x[WIDTH-1]);
    assign is_arith = (bus.operation == 3'b010) || (bus.operation == 3'b011);
    assign is_mul   = bus.operation == 3'b100;
    assign slt_res  = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
    assign alu_lo   = bus.operation == 3'b000 ? a_x & b_x :
                      bus.operation == 3'b001 ? a_x | b_x :
                      bus.operation == 3'b010 ? sum :
                      bus.operation == 3'b011 ? slt_res : '0;
    // One partial product per cycle: multiplicand walks left, multiplier walks right
    assign acc_n    = acc_q + (mplier_q[0] ? mcand_q : '0);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                if (is_mul) begin
                    state_d  = EXEC;
                    mplier_d = b_x;
                    mcand_d  = {{WIDTH{1'b0}}, a_x};
                    acc_d    = '0;
                    cnt_d    = '0;
                end else begin
                    state_d  = DONE;
                    result_d = {{WIDTH{1'b0}}, alu_lo};
                    carry_d  = is_arith & c_out;
                    ovf_d    = is_arith & ovf;
                    zero_d   = alu_lo == '0;
                end
            end
            EXEC: begin
                acc_d    = acc_n;
                mplier_d = mplier_q >> 1;
                mcand_d  = mcand_q << 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    result_d = acc_n;
                    carry_d  = |acc_n[2*WIDTH-1:WIDTH];
                    ovf_d    = 1'b0;
                    zero_d   = acc_n == '0;
                end
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: table-driven and hand-sequenced checks of 64- and 8-bit ALU instances
module tb_alu_seq_unit;
    logic clk = 1'b0;
    logic rst64, rst8;
    always #5 clk = ~clk;
    alu_seq_if #(.WIDTH(64)) b64();
    alu_seq_if #(.WIDTH(8))  b8();
    alu_seq_unit #(.WIDTH(64)) dut64 (.clk(clk), .reset(rst64), .bus(b64));
    alu_seq_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(rst8),  .bus(b8));
    typedef struct {
        logic [63:0]  a, b;
        logic         ai, bi, ci;
        logic [2:0]   op;
        logic [127:0] res;
        logic         co, z, ov;
        int           lat;
    } vec_t;
    typedef struct {
        logic [127:0] res;
        logic         co, z, ov;
    } exp_t;
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    vec_t t64[9];
    vec_t t8[9];
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask
    task automatic pop_cmp(input string tag, input logic [127:0] res, input logic co, input logic z, input logic ov);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_sb got=result exp=nothing", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_res"}, res, e.res);
        chk({tag, "_co"}, 128'(co), 128'(e.co));
        chk({tag, "_z"}, 128'(z), 128'(e.z));
        chk({tag, "_ov"}, 128'(ov), 128'(e.ov));
    endtask
    task automatic run64(input vec_t v, input string tag);
        int lat;
        b64.a = v.a; b64.b = v.b; b64.a_invert = v.ai; b64.b_invert = v.bi;
        b64.carry_in = v.ci; b64.operation = v.op; b64.in_valid = 1'b1;
        chk({tag, "_rdy"}, 128'(b64.in_ready), 128'(1));
        @(posedge clk); #1;
        b64.in_valid = 1'b0;
        sb.push_back('{v.res, v.co, v.z, v.ov});
        lat = 1;
        while (!b64.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 128'(lat), 128'(v.lat));
        pop_cmp(tag, b64.result, b64.carry_out, b64.zero, b64.overflow);
        b64.out_ready = 1'b1;
        @(posedge clk); #1;
        b64.out_ready = 1'b0;
        chk({tag, "_ovld_after"}, 128'(b64.out_valid), 128'(0));
        chk({tag, "_rdy_after"}, 128'(b64.in_ready), 128'(1));
    endtask
    task automatic run8(input vec_t v, input string tag);
        int lat;
        b8.a = v.a[7:0]; b8.b = v.b[7:0]; b8.a_invert = v.ai; b8.b_invert = v.bi;
        b8.carry_in = v.ci; b8.operation = v.op; b8.in_valid = 1'b1;
        chk({tag, "_rdy"}, 128'(b8.in_ready), 128'(1));
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        sb.push_back('{v.res, v.co, v.z, v.ov});
        lat = 1;
        while (!b8.out_valid && lat < 200) begin
            chk({tag, "_busy"}, 128'(b8.in_ready), 128'(0));
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 128'(lat), 128'(v.lat));
        pop_cmp(tag, 128'(b8.result), b8.carry_out, b8.zero, b8.overflow);
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        b8.out_ready = 1'b0;
        chk({tag, "_ovld_after"}, 128'(b8.out_valid), 128'(0));
        chk({tag, "_rdy_after"}, 128'(b8.in_ready), 128'(1));
    endtask
    initial begin
        t64[0] = '{64'd5, 64'd2, 1'b0, 1'b0, 1'b0, 3'd0, 128'd0, 1'b0, 1'b1, 1'b0, 1};
        t64[1] = '{64'd5, 64'd2, 1'b0, 1'b0, 1'b0, 3'd1, 128'd7, 1'b0, 1'b0, 1'b0, 1};
        t64[2] = '{64'd5, 64'd2, 1'b0, 1'b0, 1'b0, 3'd2, 128'd7, 1'b0, 1'b0, 1'b0, 1};
        t64[3] = '{64'd5, 64'd2, 1'b0, 1'b1, 1'b1, 3'd2, 128'd3, 1'b1, 1'b0, 1'b0, 1};
        t64[4] = '{64'd5, 64'd2, 1'b1, 1'b0, 1'b0, 3'd2, 128'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b0, 1};
        t64[5] = '{64'd5, 64'd2, 1'b0, 1'b1, 1'b1, 3'd3, 128'd0, 1'b1, 1'b1, 1'b0, 1};
        t64[6] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 1'b1, 3'd3, 128'd1, 1'b1, 1'b0, 1'b1, 1};
        t64[7] = '{64'd5, 64'd2, 1'b0, 1'b0, 1'b1, 3'd6, 128'd0, 1'b0, 1'b1, 1'b0, 1};
        t64[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0, 1'b1, 3'd4,
                   128'h1_FFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 65};
        t8[0] = '{64'h7F, 64'h01, 1'b0, 1'b0, 1'b0, 3'd2, 128'h80, 1'b0, 1'b0, 1'b1, 1};
        t8[1] = '{64'h80, 64'h01, 1'b0, 1'b1, 1'b1, 3'd3, 128'h01, 1'b1, 1'b0, 1'b1, 1};
        t8[2] = '{64'h05, 64'h02, 1'b0, 1'b1, 1'b1, 3'd3, 128'h00, 1'b1, 1'b1, 1'b0, 1};
        t8[3] = '{64'hFF, 64'hFF, 1'b0, 1'b0, 1'b0, 3'd4, 128'hFE01, 1'b1, 1'b0, 1'b0, 9};
        t8[4] = '{64'hF0, 64'h3C, 1'b1, 1'b0, 1'b0, 3'd0, 128'h0C, 1'b0, 1'b0, 1'b0, 1};
        t8[5] = '{64'hFF, 64'hFF, 1'b0, 1'b0, 1'b1, 3'd7, 128'h00, 1'b0, 1'b1, 1'b0, 1};
        t8[6] = '{64'h10, 64'h0F, 1'b0, 1'b0, 1'b1, 3'd4, 128'hF0, 1'b0, 1'b0, 1'b0, 9};
        t8[7] = '{64'hFF, 64'h01, 1'b0, 1'b0, 1'b0, 3'd2, 128'h00, 1'b1, 1'b1, 1'b0, 1};
        t8[8] = '{64'h00, 64'hA5, 1'b0, 1'b0, 1'b0, 3'd4, 128'h00, 1'b0, 1'b1, 1'b0, 9};
        {b64.in_valid, b64.out_ready, b64.a_invert, b64.b_invert, b64.carry_in} = '0;
        {b8.in_valid, b8.out_ready, b8.a_invert, b8.b_invert, b8.carry_in} = '0;
        b64.a = '0; b64.b = '0; b64.operation = '0;
        b8.a = '0; b8.b = '0; b8.operation = '0;
        rst64 = 1'b1;
        rst8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy64", 128'(b64.in_ready), 128'(1));
        chk("rst_ovld64", 128'(b64.out_valid), 128'(0));
        chk("rst_res64", b64.result, 128'd0);
        chk("rst_res8", 128'(b8.result), 128'd0);
        chk("rst_flags8", 128'({b8.carry_out, b8.zero, b8.overflow, b8.out_valid}), 128'(0));
        rst64 = 1'b0;
        rst8 = 1'b0;
        @(posedge clk); #1;
        foreach (t64[i]) run64(t64[i], $sformatf("w64_%0d", i));
        foreach (t8[i]) run8(t8[i], $sformatf("w8_%0d", i));
        for (int i = 0; i < 4; i++) begin
            vec_t v;
            logic [15:0] p;
            v.a = 64'($urandom_range(0, 255));
            v.b = 64'($urandom_range(0, 255));
            p = v.a[7:0] * v.b[7:0];
            v.ai = 1'b0; v.bi = 1'b0; v.ci = 1'b0; v.op = 3'd4;
            v.res = 128'(p); v.co = |p[15:8]; v.z = p == 16'd0; v.ov = 1'b0; v.lat = 9;
            run8(v, $sformatf("rmul_%0d", i));
        end
        // MUL under backpressure with stray commands during EXEC and DONE
        b8.a = 8'hFF; b8.b = 8'hFF; b8.a_invert = 1'b0; b8.b_invert = 1'b0;
        b8.carry_in = 1'b0; b8.operation = 3'd4; b8.in_valid = 1'b1;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        sb.push_back('{128'hFE01, 1'b1, 1'b0, 1'b0});
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("bp_exec_rdy_%0d", i), 128'(b8.in_ready), 128'(0));
            chk($sformatf("bp_exec_ovld_%0d", i), 128'(b8.out_valid), 128'(0));
            if (i == 3) begin
                b8.in_valid = 1'b1; b8.operation = 3'd2; b8.a = 8'h01; b8.b = 8'h01;
            end
            @(posedge clk); #1;
        end
        chk("bp_ovld_n9", 128'(b8.out_valid), 128'(1));
        pop_cmp("bp", 128'(b8.result), b8.carry_out, b8.zero, b8.overflow);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold_res_%0d", i), 128'(b8.result), 128'hFE01);
            chk($sformatf("bp_hold_co_%0d", i), 128'(b8.carry_out), 128'(1));
            chk($sformatf("bp_hold_ovld_%0d", i), 128'(b8.out_valid), 128'(1));
            chk($sformatf("bp_hold_rdy_%0d", i), 128'(b8.in_ready), 128'(0));
        end
        b8.in_valid = 1'b0;
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        b8.out_ready = 1'b0;
        chk("bp_taken_ovld", 128'(b8.out_valid), 128'(0));
        chk("bp_taken_rdy", 128'(b8.in_ready), 128'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_queue", 128'(b8.out_valid), 128'(0));
        // Reset in the middle of a multiply
        b8.a = 8'hFF; b8.b = 8'hFF; b8.operation = 3'd4; b8.in_valid = 1'b1;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst8 = 1'b1;
        #1;
        chk("abort_ovld", 128'(b8.out_valid), 128'(0));
        chk("abort_rdy", 128'(b8.in_ready), 128'(1));
        @(posedge clk); #1;
        rst8 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_result", 128'(b8.out_valid), 128'(0));
        run8('{64'd3, 64'd4, 1'b0, 1'b0, 1'b0, 3'd2, 128'd7, 1'b0, 1'b0, 1'b0, 1}, "post_rst_add");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised, handshaked successor to the 64-bit combinational ALU. It adds configurable width, a registered result, status flags, set-less-than, and a multi-cycle unsigned multiply. It keeps the established aInvert/bInvert/carryIn/operation control scheme and sits between the operand-issue logic and the writeback stage on a valid/ready interface.

## Interface
- WIDTH, 64, operand width in bits (≥ 4)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- inValid  input  1  operand/command valid
- inReady  output  1  unit can accept a command
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- aInvert  input  1  use ~a instead of a
- bInvert  input  1  use ~b instead of b
- carryIn  input  1  adder carry-in
- operation  input  3  000 AND, 001 OR, 010 ADD, 011 SLT, 100 MUL, 101–111 reserved
- outValid  output  1  result valid
- outReady  input  1  downstream accepts result
- result  output  2*WIDTH  result; upper WIDTH bits are zero except for MUL
- carryOut  output  1  adder carry (ADD/SLT); upper-half-nonzero (MUL)
- zero  output  1  result == 0 over all 2*WIDTH bits
- overflow  output  1  signed overflow of the adder (ADD/SLT only)

## Operation
- Command transfer occurs when inValid && inReady.
- At transfer, the unit captures A' = aInvert ? ~a : a, B' = bInvert ? ~b : b, carryIn and operation. Later input changes have no effect.
- AND: A' & B'. OR: A' | B'. carryOut = 0 and overflow = 0 for both.
- ADD: {carryOut, sum} = A' + B' + carryIn (WIDTH+1 bits); result = sum. Subtraction is bInvert=1 with carryIn=1.
- overflow (ADD/SLT) = (A'[W-1] == B'[W-1]) && (sum[W-1] != A'[W-1]).
- SLT: the adder is computed as for ADD. result = {0…0, sum[W-1] ^ overflow}. carryOut and overflow report the adder.
- MUL: unsigned A' × B'. carryIn is ignored. Implemented as shift-add, one partial product per cycle, WIDTH cycles. result = 2*WIDTH-bit product; carryOut = |product[2W-1:W]; overflow = 0.
- Reserved opcodes: single-cycle; result = 0, carryOut = 0, overflow = 0, zero = 1.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: inReady = 1. On transfer, non-MUL opcodes go to DONE with results registered. MUL goes to EXEC with counter = 0 and accumulator = 0.
  - EXEC: one iteration per cycle. After WIDTH iterations, latch the product and flags and go to DONE.
  - DONE: outValid = 1. When outReady = 1, go to IDLE.
- While outValid && !outReady, result and all flags are held stable.
- inReady is 1 only in IDLE. No command is accepted in EXEC or DONE, including the cycle in which the result is taken.

## Timing
- Reset values: state IDLE, inReady 1, outValid 0, result 0, carryOut 0, zero 0, overflow 0. Multiply counter and accumulator are cleared.
- Reset asserted in any state (including mid-MUL or DONE) aborts the operation. No result is ever presented for an aborted command.
- Non-MUL latency: transfer in cycle N, outValid = 1 in cycle N+1.
- MUL latency: transfer in cycle N, outValid = 1 in cycle N+WIDTH+1.
- Result taken in cycle M (outValid && outReady): outValid = 0 and inReady = 1 in cycle M+1.
- Maximum throughput: one non-MUL command every 2 cycles; one MUL every WIDTH+2 cycles.
- outReady asserted while outValid = 0 has no effect.
- inValid asserted while inReady = 0 is ignored. The command is not queued.

## Test plan
- WIDTH=64, a=5, b=2, no inverts, carryIn=0:
  - AND → result 0, zero 1.
  - OR → 7.
  - ADD → 7, carryOut 0.
  - Each has outValid exactly 1 cycle after transfer.
- WIDTH=64, a=5, b=2, bInvert=1, carryIn=1, ADD → result 3, carryOut 1, overflow 0.
- WIDTH=64, a=5, b=2, aInvert=1, carryIn=0, ADD → lower half 0xFFFF_FFFF_FFFF_FFFC, upper half 0, carryOut 0.
- WIDTH=8:
  - ADD a=0x7F, b=0x01 → 0x80, overflow 1.
  - SLT a=0x80, b=0x01 (bInvert=1, carryIn=1) → result 1, overflow 1.
  - SLT a=0x05, b=0x02 (bInvert=1, carryIn=1) → result 0.
- WIDTH=8, MUL a=0xFF, b=0xFF:
  - result 0xFE01, carryOut 1, outValid at N+9, inReady 0 throughout.
  - With outReady held low for 3 cycles, outputs are unchanged until transfer, and inValid pulses during EXEC/DONE are ignored.
- WIDTH=8:
  - Reset asserted at EXEC cycle 4 of a MUL → outValid 0 and inReady 1 immediately.
  - After reset release, ADD 3+4 → 7 with no residual product.
